// File: rtl/ysyx_23060201_lsu.sv
// ysyx_23060201_lsu: load/store unit, initiator side of the core memory port.
// Accepts one access from EXU, issues it on mem_*, waits for the response and
// returns extended load data (or 0 for stores) to WBU.
// Optional watchdog: define YSYX_23060201_LSU_TIMEOUT_EN to abort an access
// that sees no response within TIMEOUT cycles (err=1).
module ysyx_23060201_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lsu_valid_i,
   output logic                  lsu_ready_o,
   input  logic                  lsu_wen_i,
   input  logic [2:0]            lsu_funct3_i,
   input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
   input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
   output logic                  lsu_rvalid_o,
   input  logic                  lsu_rready_i,
   output logic [DATA_WIDTH-1:0] lsu_rdata_o,
   output logic                  lsu_err_o,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   output logic [7:0]            mem_rmask,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [7:0]            mem_wmask,
   input  logic                  mem_req_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rvalid,
   input  logic                  mem_bvalid
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t     state;
   logic       wen_q;
   logic [2:0] funct3_q;
   logic [1:0] off_q;

   logic [1:0]            in_off;
   logic                  funct3_ok;
   logic                  aligned;
   logic                  legal;
   logic [3:0]            in_mask;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] load_ext;
   logic                  resp_hit;
   logic                  tmo_hit;

   // Decode the incoming request: legality, alignment and byte-lane mask
   always_comb begin
      in_off    = lsu_addr_i[1:0];
      funct3_ok = 1'b0;
      aligned   = 1'b0;
      in_mask   = 4'b0000;
      case (lsu_funct3_i)
         3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
         3'b100, 3'b101:         funct3_ok = ~lsu_wen_i;
         default:                funct3_ok = 1'b0;
      endcase
      case (lsu_funct3_i[1:0])
         2'b00: begin
            aligned = 1'b1;
            in_mask = 4'b0001 << in_off;
         end
         2'b01: begin
            aligned = ~in_off[0];
            in_mask = 4'b0011 << in_off;
         end
         default: begin
            aligned = (in_off == 2'b00);
            in_mask = 4'b1111;
         end
      endcase
      legal = funct3_ok & aligned;
   end

   // Align and extend returned load data; pick the response type that counts
   always_comb begin
      shifted = mem_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
      resp_hit = wen_q ? mem_bvalid : mem_rvalid;
   end

`ifdef YSYX_23060201_LSU_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CW-1:0] tmo_cnt;

   // Watchdog: counts cycles spent in REQ/WAIT, zero elsewhere (so zero on REQ entry)
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state == REQ || state == WAIT) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
      end
   end

   // Fires on the last counted cycle so RESP is entered exactly TIMEOUT cycles after REQ entry
   assign tmo_hit = (state == REQ || state == WAIT) && (tmo_cnt == CW'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // Main FSM with registered request and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wen_q        <= 1'b0;
         funct3_q     <= '0;
         off_q        <= '0;
         lsu_ready_o  <= 1'b1;
         lsu_rvalid_o <= 1'b0;
         lsu_rdata_o  <= '0;
         lsu_err_o    <= 1'b0;
         mem_ren      <= 1'b0;
         mem_raddr    <= '0;
         mem_rmask    <= '0;
         mem_wen      <= 1'b0;
         mem_waddr    <= '0;
         mem_wdata    <= '0;
         mem_wmask    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (lsu_valid_i) begin
                  wen_q       <= lsu_wen_i;
                  funct3_q    <= lsu_funct3_i;
                  off_q       <= in_off;
                  lsu_ready_o <= 1'b0;
                  if (legal) begin
                     state <= REQ;
                     if (lsu_wen_i) begin
                        mem_wen   <= 1'b1;
                        mem_waddr <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_wmask <= {4'b0000, in_mask};
                        mem_wdata <= lsu_wdata_i << {in_off, 3'b000};
                     end else begin
                        mem_ren   <= 1'b1;
                        mem_raddr <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_rmask <= {4'b0000, in_mask};
                     end
                  end else begin
                     state        <= RESP;
                     lsu_rvalid_o <= 1'b1;
                     lsu_err_o    <= 1'b1;
                     lsu_rdata_o  <= '0;
                  end
               end
            end
            REQ, WAIT: begin
               // REQ and WAIT share the completion logic; in REQ a response only
               // counts when it coincides with mem_req_ready.
               if (state == WAIT || mem_req_ready || tmo_hit) begin
                  mem_ren   <= 1'b0;
                  mem_raddr <= '0;
                  mem_rmask <= '0;
                  mem_wen   <= 1'b0;
                  mem_waddr <= '0;
                  mem_wdata <= '0;
                  mem_wmask <= '0;
               end
               if ((state == WAIT || mem_req_ready) && resp_hit) begin
                  state        <= RESP;
                  lsu_rvalid_o <= 1'b1;
                  lsu_err_o    <= 1'b0;
                  lsu_rdata_o  <= wen_q ? '0 : load_ext;
               end else if (tmo_hit) begin
                  state        <= RESP;
                  lsu_rvalid_o <= 1'b1;
                  lsu_err_o    <= 1'b1;
                  lsu_rdata_o  <= '0;
               end else if (state == REQ && mem_req_ready) begin
                  state <= WAIT;
               end
            end
            RESP: begin
               if (lsu_rready_i) begin
                  state        <= IDLE;
                  lsu_rvalid_o <= 1'b0;
                  lsu_rdata_o  <= '0;
                  lsu_err_o    <= 1'b0;
                  lsu_ready_o  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// tb_ysyx_23060201_lsu: directed self-checking bench for the load/store unit.
// Build with YSYX_23060201_LSU_TIMEOUT_EN defined to exercise the watchdog.
module tb_ysyx_23060201_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_valid_i;
   logic        lsu_ready_o;
   logic        lsu_wen_i;
   logic [2:0]  lsu_funct3_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic        lsu_rvalid_o;
   logic        lsu_rready_i;
   logic [31:0] lsu_rdata_o;
   logic        lsu_err_o;
   logic        mem_ren;
   logic [31:0] mem_raddr;
   logic [7:0]  mem_rmask;
   logic        mem_wen;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_req_ready;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        mem_bvalid;

   int unsigned n_run  = 0;
   int unsigned n_fail = 0;

   ysyx_23060201_lsu #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
      .lsu_wen_i(lsu_wen_i), .lsu_funct3_i(lsu_funct3_i),
      .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
      .lsu_rvalid_o(lsu_rvalid_o), .lsu_rready_i(lsu_rready_i),
      .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_req_ready(mem_req_ready),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_bvalid(mem_bvalid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present one request for a single cycle; returns at the negedge after the accepting edge
   task automatic send(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
      check("ready_before_req", 32'(lsu_ready_o), 32'd1);
      lsu_valid_i  = 1'b1;
      lsu_wen_i    = wen;
      lsu_funct3_i = f3;
      lsu_addr_i   = addr;
      lsu_wdata_i  = wdata;
      @(negedge clk);
      lsu_valid_i  = 1'b0;
   endtask

   task automatic accept_req();
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
   endtask

   task automatic pulse_r(input logic [31:0] d);
      mem_rdata  = d;
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
   endtask

   task automatic pulse_b();
      mem_bvalid = 1'b1;
      @(negedge clk);
      mem_bvalid = 1'b0;
   endtask

   // Check the pending result, complete the WBU handshake, check return to idle
   task automatic retire(input string tag, input logic [31:0] d, input logic e);
      check({tag, "_rvalid"}, 32'(lsu_rvalid_o), 32'd1);
      check({tag, "_rdata"}, lsu_rdata_o, d);
      check({tag, "_err"}, 32'(lsu_err_o), 32'(e));
      lsu_rready_i = 1'b1;
      @(negedge clk);
      lsu_rready_i = 1'b0;
      check({tag, "_rvalid_drop"}, 32'(lsu_rvalid_o), 32'd0);
      check({tag, "_ready_back"}, 32'(lsu_ready_o), 32'd1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"}, 32'(lsu_ready_o), 32'd1);
      check({tag, "_rvalid"}, 32'(lsu_rvalid_o), 32'd0);
      check({tag, "_rdata"}, lsu_rdata_o, 32'd0);
      check({tag, "_err"}, 32'(lsu_err_o), 32'd0);
      check({tag, "_req"}, {30'd0, mem_ren, mem_wen}, 32'd0);
      check({tag, "_raddr"}, mem_raddr, 32'd0);
      check({tag, "_waddr"}, mem_waddr, 32'd0);
      check({tag, "_wdata"}, mem_wdata, 32'd0);
      check({tag, "_masks"}, {16'd0, mem_rmask, mem_wmask}, 32'd0);
   endtask

   // Illegal request: never touches memory and reports err within two cycles
   task automatic illegal(input string tag, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr);
      send(wen, f3, addr, 32'hFFFF_FFFF);
      for (int i = 0; i < 2; i++) begin
         check({tag, "_noreq"}, {30'd0, mem_ren, mem_wen}, 32'd0);
         if (lsu_rvalid_o) break;
         @(negedge clk);
      end
      retire(tag, 32'd0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      rst = 1'b1;
      lsu_valid_i = 1'b0; lsu_wen_i = 1'b0; lsu_funct3_i = 3'b000;
      lsu_addr_i = '0; lsu_wdata_i = '0; lsu_rready_i = 1'b0;
      mem_req_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0; mem_bvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_idle("reset");

      // LW with 3-cycle ready delay, response in WAIT
      send(1'b0, 3'b010, 32'h8000_0004, '0);
      for (int i = 0; i < 3; i++) begin
         check("lw_ren_held", 32'(mem_ren), 32'd1);
         check("lw_raddr_held", mem_raddr, 32'h8000_0004);
         check("lw_rmask_held", 32'(mem_rmask), 32'h0F);
         check("lw_busy", 32'(lsu_ready_o), 32'd0);
         @(negedge clk);
      end
      accept_req();
      check("lw_wait_ren_low", 32'(mem_ren), 32'd0);
      check("lw_wait_no_result", 32'(lsu_rvalid_o), 32'd0);
      pulse_b();
      check("lw_wrong_type_ignored", 32'(lsu_rvalid_o), 32'd0);
      pulse_r(32'hDEAD_BEEF);
      retire("lw", 32'hDEAD_BEEF, 1'b0);

      // LB at lane 3, ready and data in the same cycle (minimum latency)
      send(1'b0, 3'b000, 32'h8000_0003, '0);
      check("lb_rmask", 32'(mem_rmask), 32'h08);
      check("lb_raddr", mem_raddr, 32'h8000_0000);
      mem_req_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h8011_2233;
      @(negedge clk);
      mem_req_ready = 1'b0; mem_rvalid = 1'b0;
      retire("lb", 32'hFFFF_FF80, 1'b0);

      // LBU same access
      send(1'b0, 3'b100, 32'h8000_0003, '0);
      accept_req();
      pulse_r(32'h8011_2233);
      retire("lbu", 32'h0000_0080, 1'b0);

      // LH / LHU upper half
      send(1'b0, 3'b001, 32'h8000_0012, '0);
      check("lh_rmask", 32'(mem_rmask), 32'h0C);
      check("lh_raddr", mem_raddr, 32'h8000_0010);
      accept_req();
      pulse_r(32'h8001_7777);
      retire("lh", 32'hFFFF_8001, 1'b0);
      send(1'b0, 3'b101, 32'h8000_0012, '0);
      accept_req();
      pulse_r(32'h8001_7777);
      retire("lhu", 32'h0000_8001, 1'b0);

      // SH at lane 2
      send(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD);
      check("sh_wen", {30'd0, mem_ren, mem_wen}, 32'd1);
      check("sh_waddr", mem_waddr, 32'h8000_0000);
      check("sh_wmask", 32'(mem_wmask), 32'h0C);
      check("sh_wdata", mem_wdata, 32'hABCD_0000);
      accept_req();
      check("sh_wait_wen_low", 32'(mem_wen), 32'd0);
      pulse_r(32'h5555_5555);
      check("sh_wrong_type_ignored", 32'(lsu_rvalid_o), 32'd0);
      pulse_b();
      retire("sh", 32'd0, 1'b0);

      // SB lane 1, SW with same-cycle bvalid
      send(1'b1, 3'b000, 32'h8000_0101, 32'h0000_00A5);
      check("sb_wmask", 32'(mem_wmask), 32'h02);
      check("sb_wdata", mem_wdata, 32'h0000_A500);
      check("sb_waddr", mem_waddr, 32'h8000_0100);
      accept_req();
      pulse_b();
      retire("sb", 32'd0, 1'b0);
      send(1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D);
      check("sw_wmask", 32'(mem_wmask), 32'h0F);
      check("sw_wdata", mem_wdata, 32'hCAFE_F00D);
      mem_req_ready = 1'b1; mem_bvalid = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0; mem_bvalid = 1'b0;
      retire("sw", 32'd0, 1'b0);

      // Illegal requests
      illegal("lw_misaligned", 1'b0, 3'b010, 32'h8000_0001);
      illegal("funct3_011", 1'b0, 3'b011, 32'h8000_0000);
      illegal("sh_misaligned", 1'b1, 3'b001, 32'h8000_0003);
      illegal("store_funct3_100", 1'b1, 3'b100, 32'h8000_0000);

      // WBU backpressure for 5 cycles
      send(1'b0, 3'b010, 32'h8000_0020, '0);
      accept_req();
      pulse_r(32'h0BAD_F00D);
      for (int i = 0; i < 5; i++) begin
         check("hold_rvalid", 32'(lsu_rvalid_o), 32'd1);
         check("hold_rdata", lsu_rdata_o, 32'h0BAD_F00D);
         check("hold_err", 32'(lsu_err_o), 32'd0);
         check("hold_ready_low", 32'(lsu_ready_o), 32'd0);
         @(negedge clk);
      end
      retire("hold", 32'h0BAD_F00D, 1'b0);

      // Reset during WAIT, then late responses
      send(1'b0, 3'b010, 32'h8000_0030, '0);
      accept_req();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("rst_wait");
      pulse_r(32'h1111_1111);
      pulse_b();
      check_idle("late_resp");

`ifdef YSYX_23060201_LSU_TIMEOUT_EN
      // Memory never accepts: err exactly 8 cycles after REQ entry
      send(1'b0, 3'b010, 32'h8000_0040, '0);
      for (int i = 0; i < 8; i++) begin
         check("tmo_not_yet", 32'(lsu_rvalid_o), 32'd0);
         @(negedge clk);
      end
      check("tmo_req_dropped", 32'(mem_ren), 32'd0);
      retire("tmo", 32'd0, 1'b1);
      pulse_r(32'h2222_2222);
      check_idle("tmo_late");
`else
      // No watchdog: still waiting long after the response is due
      send(1'b0, 3'b010, 32'h8000_0040, '0);
      accept_req();
      repeat (20) @(negedge clk);
      check("notmo_rvalid", 32'(lsu_rvalid_o), 32'd0);
      check("notmo_err", 32'(lsu_err_o), 32'd0);
      check("notmo_busy", 32'(lsu_ready_o), 32'd0);
      pulse_r(32'h2222_2222);
      retire("notmo", 32'h2222_2222, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
